// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - SOF/length/payload/checksum frame assembler behind the UART receiver
// Validated payloads are held in a small register buffer until the consumer acks them.
module uart_frame_rx #(
  parameter int         ADDR_W  = 4,
  parameter logic [7:0] SOF     = 8'hA5,
  parameter int         TIMEOUT = 4000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_finish,
  input  logic              frame_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_byte,
  output logic              frame_valid,
  output logic [ADDR_W:0]   frame_len,
  output logic              err_chk,
  output logic              err_len,
  output logic              err_timeout,
  output logic              err_ovf
);

  localparam logic [2:0]  S_IDLE = 3'd0;
  localparam logic [2:0]  S_LEN  = 3'd1;
  localparam logic [2:0]  S_PAY  = 3'd2;
  localparam logic [2:0]  S_CHK  = 3'd3;
  localparam logic [2:0]  S_HOLD = 3'd4;
  localparam int          MAX_LEN   = 2 ** ADDR_W;
  localparam logic [8:0]  MAX_LEN_W = 9'(MAX_LEN);
  localparam logic [15:0] GAP_LAST  = 16'(TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic              fin_q;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        chk_q, chk_d;
  logic [15:0]       gap_q, gap_d;
  logic              frame_valid_q, frame_valid_d;
  logic [ADDR_W:0]   frame_len_q, frame_len_d;
  logic              err_chk_q, err_chk_d;
  logic              err_len_q, err_len_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_ovf_q, err_ovf_d;
  logic              stb;
  logic              wr_en;
  logic [7:0]        mem_q [MAX_LEN];

  assign stb = rx_finish & ~fin_q;

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    idx_d         = idx_q;
    chk_d         = chk_q;
    gap_d         = gap_q;
    frame_valid_d = frame_valid_q;
    frame_len_d   = frame_len_q;
    err_chk_d     = 1'b0;
    err_len_d     = 1'b0;
    err_timeout_d = 1'b0;
    err_ovf_d     = 1'b0;
    wr_en         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (stb && rx_data == SOF) state_d = S_LEN;
      end
      S_LEN: begin
        if (stb) begin
          if (rx_data == 8'h00 || {1'b0, rx_data} > MAX_LEN_W) begin
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            len_d   = rx_data[ADDR_W:0];
            chk_d   = rx_data;
            idx_d   = '0;
            state_d = S_PAY;
          end
        end
      end
      S_PAY: begin
        if (stb) begin
          wr_en = 1'b1;
          chk_d = chk_q ^ rx_data;
          idx_d = idx_q + ADDR_W'(1);
          if ({1'b0, idx_q} == len_q - (ADDR_W + 1)'(1)) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (stb) begin
          if (rx_data == chk_q) begin
            frame_valid_d = 1'b1;
            frame_len_d   = len_q;
            state_d       = S_HOLD;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        // The held frame is never overwritten; late bytes are only reported.
        if (stb) err_ovf_d = 1'b1;
        if (frame_ack) begin
          frame_valid_d = 1'b0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A strobe landing on the final gap cycle takes priority over the abort.
    if (state_q == S_LEN || state_q == S_PAY || state_q == S_CHK) begin
      if (stb) begin
        gap_d = '0;
      end else if (gap_q == GAP_LAST) begin
        err_timeout_d = 1'b1;
        gap_d         = '0;
        state_d       = S_IDLE;
      end else begin
        gap_d = gap_q + 16'd1;
      end
    end else begin
      gap_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      fin_q         <= 1'b1;
      len_q         <= '0;
      idx_q         <= '0;
      chk_q         <= '0;
      gap_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= '0;
      err_chk_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fin_q         <= rx_finish;
      len_q         <= len_d;
      idx_q         <= idx_d;
      chk_q         <= chk_d;
      gap_q         <= gap_d;
      frame_valid_q <= frame_valid_d;
      frame_len_q   <= frame_len_d;
      err_chk_q     <= err_chk_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
      err_ovf_q     <= err_ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[idx_q] <= rx_data;
  end

  assign rd_byte     = mem_q[rd_addr];
  assign frame_valid = frame_valid_q;
  assign frame_len   = frame_len_q;
  assign err_chk     = err_chk_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_timeout_q;
  assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - directed bench for uart_frame_rx with a payload scoreboard
// Expected frames are queued as they are sent and popped when frame_valid is observed.
module tb_uart_frame_rx;

  localparam int ADDR_W = 4;
  localparam int TO     = 4000;

  logic              clock;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_finish;
  logic              frame_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_byte;
  logic              frame_valid;
  logic [ADDR_W:0]   frame_len;
  logic              err_chk, err_len, err_timeout, err_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int c_chk = 0, c_len = 0, c_to = 0, c_ovf = 0;
  int e_chk = 0, e_len = 0, e_to = 0, e_ovf = 0;

  logic [7:0] exp_bytes[$];
  int         exp_lens[$];
  logic [7:0] txq[$];

  uart_frame_rx #(.ADDR_W(ADDR_W), .SOF(8'hA5), .TIMEOUT(TO)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_finish  (rx_finish),
    .frame_ack  (frame_ack),
    .rd_addr    (rd_addr),
    .rd_byte    (rd_byte),
    .frame_valid(frame_valid),
    .frame_len  (frame_len),
    .err_chk    (err_chk),
    .err_len    (err_len),
    .err_timeout(err_timeout),
    .err_ovf    (err_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (err_chk)     c_chk++;
    if (err_len)     c_len++;
    if (err_timeout) c_to++;
    if (err_ovf)     c_ovf++;
    if (err_chk | err_len | err_timeout | err_ovf) begin
      n_cmp++;
      assert ($countones({err_chk, err_len, err_timeout, err_ovf}) == 1) else begin
        n_bad++;
        $error("FAIL err_onehot observed=%b expected=one bit set",
               {err_chk, err_len, err_timeout, err_ovf});
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data   = b;
    rx_finish = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rx_finish = 1'b0;
    @(negedge clock);
  endtask

  task automatic send_txq();
    foreach (txq[i]) send_byte(txq[i]);
  endtask

  // Payload is taken from txq; checksum is computed here and the frame is queued.
  task automatic send_good();
    logic [7:0] chk;
    logic [7:0] pay[$];
    pay = txq;
    chk = 8'(pay.size());
    exp_lens.push_back(pay.size());
    foreach (pay[i]) begin
      chk ^= pay[i];
      exp_bytes.push_back(pay[i]);
    end
    send_byte(8'hA5);
    send_byte(8'(pay.size()));
    foreach (pay[i]) send_byte(pay[i]);
    send_byte(chk);
  endtask

  task automatic check_frame(input string tag);
    int k;
    int len;
    k = 0;
    while (!frame_valid && k < 20) begin
      @(negedge clock);
      k++;
    end
    check({tag, "_valid"}, 32'(frame_valid), 32'd1);
    if (exp_lens.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s_sb observed=frame expected=none queued", tag);
    end else begin
      len = exp_lens.pop_front();
      check({tag, "_len"}, 32'(frame_len), 32'(len));
      for (int i = 0; i < len; i++) begin
        rd_addr = ADDR_W'(i);
        #1;
        check($sformatf("%s_byte%0d", tag, i), 32'(rd_byte), 32'(exp_bytes.pop_front()));
      end
    end
    @(negedge clock);
  endtask

  task automatic check_errs(input string tag);
    @(negedge clock);
    check({tag, "_nchk"}, 32'(c_chk), 32'(e_chk));
    check({tag, "_nlen"}, 32'(c_len), 32'(e_len));
    check({tag, "_nto"},  32'(c_to),  32'(e_to));
    check({tag, "_novf"}, 32'(c_ovf), 32'(e_ovf));
  endtask

  task automatic do_ack(input string tag);
    frame_ack = 1'b1;
    @(posedge clock);
    @(negedge clock);
    frame_ack = 1'b0;
    check({tag, "_ack_valid"}, 32'(frame_valid), 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    rx_finish = 1'b1;
    rx_data   = 8'hA5;
    frame_ack = 1'b0;
    rd_addr   = '0;
    repeat (3) @(negedge clock);
    check("rst_valid", 32'(frame_valid), 32'd0);
    check("rst_len", 32'(frame_len), 32'd0);
    check("rst_errs", 32'({err_chk, err_len, err_timeout, err_ovf}), 32'd0);

    // rx_finish already high at release must not produce a strobe
    reset = 1'b1;
    repeat (4) @(negedge clock);
    rx_finish = 1'b0;
    @(negedge clock);

    txq = '{8'h00, 8'hFF, 8'h7E};
    send_txq();
    txq = '{8'h11, 8'h22, 8'h33};
    send_good();
    check_frame("good3");
    check_errs("good3");
    do_ack("good3");

    txq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'hFF};
    send_txq();
    e_chk++;
    check_errs("badchk");
    check("badchk_valid", 32'(frame_valid), 32'd0);
    txq = '{8'h44, 8'h55};
    send_good();
    check_frame("after_bad");
    do_ack("after_bad");

    txq = '{8'hA5, 8'h00, 8'hA5, 8'h11};
    send_txq();
    e_len += 2;
    check_errs("badlen");
    txq = {};
    for (int i = 0; i < 16; i++) txq.push_back(8'(i * 7 + 1));
    send_good();
    check_frame("len16");
    check_errs("len16");
    do_ack("len16");

    txq = '{8'hA5, 8'h02, 8'h10};
    send_txq();
    repeat (TO - 2) @(negedge clock);
    check("to_early", 32'(err_timeout), 32'd0);
    @(negedge clock);
    check("to_fire", 32'(err_timeout), 32'd1);
    e_to++;
    check_errs("timeout");
    check("to_valid", 32'(frame_valid), 32'd0);

    // Payload byte arrives exactly on the timeout edge and must be kept.
    exp_lens.push_back(2);
    exp_bytes.push_back(8'h10);
    exp_bytes.push_back(8'h20);
    txq = '{8'hA5, 8'h02, 8'h10};
    send_txq();
    repeat (TO - 2) @(negedge clock);
    send_byte(8'h20);
    send_byte(8'h32);
    check_errs("to_race");

    send_byte(8'h55);
    send_byte(8'h66);
    e_ovf += 2;
    check_frame("ovf_held");
    check_errs("ovf");

    rx_data   = 8'hA5;
    rx_finish = 1'b1;
    frame_ack = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rx_finish = 1'b0;
    frame_ack = 1'b0;
    check("ackstb_valid", 32'(frame_valid), 32'd0);
    @(negedge clock);
    e_ovf++;
    check_errs("ackstb");
    txq = '{8'h99};
    send_good();
    check_frame("after_ackstb");
    do_ack("after_ackstb");

    txq = '{8'hA5, 8'h03, 8'h11};
    send_txq();
    reset     = 1'b0;
    rx_finish = 1'b1;
    rx_data   = 8'hA5;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    rx_finish = 1'b0;
    @(negedge clock);
    check("midrst_valid", 32'(frame_valid), 32'd0);
    check("midrst_len", 32'(frame_len), 32'd0);
    txq = '{8'hAB, 8'hCD, 8'hCE};
    send_good();
    check_frame("midrst");
    check_errs("midrst");
    do_ack("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Byte-to-frame assembler directly downstream of the UART receiver. Consumes each received byte (`rx_data` qualified by the rising edge of `rx_finish`) and parses SOF/length/payload/checksum frames carrying game moves and commands. Validated payloads are buffered for the game controller. Malformed, stalled or overrunning frames are dropped and flagged with one-cycle error pulses.

## Interface
- `ADDR_W`, 4: payload buffer address width. `MAX_LEN` = 2**`ADDR_W` bytes.
- `SOF`, 8'hA5: start-of-frame byte.
- `TIMEOUT`, 4000: maximum clocks allowed between bytes inside a frame. Range 2..65535.

- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte from the UART; stable while `rx_finish` is high.
- `rx_finish`  in  1  UART byte-done level; rises once per received byte.
- `frame_ack`  in  1  consumer has read the frame; one-cycle pulse.
- `rd_addr`  in  ADDR_W  payload read index.
- `rd_byte`  out  8  combinational read of buffer[`rd_addr`].
- `frame_valid`  out  1  a complete, checked frame is held.
- `frame_len`  out  ADDR_W+1  payload length of the held frame.
- `err_chk`  out  1  checksum mismatch pulse.
- `err_len`  out  1  illegal length pulse.
- `err_timeout`  out  1  inter-byte timeout pulse.
- `err_ovf`  out  1  byte dropped while a frame is held; pulse.

## Operation
- Frame format: `SOF`, LEN (1..MAX_LEN), LEN payload bytes, CHK.
- CHK = XOR of LEN and all payload bytes.
- Byte strobe: `stb` = `rx_finish` & ~`fin_q`, where `fin_q` is `rx_finish` registered. `fin_q` resets to 1, so a high `rx_finish` at reset release produces no strobe. `rx_data` is used in the strobe cycle.
- IDLE: on strobe, if byte == `SOF` go to LEN. Any other byte is discarded silently.
- LEN: on strobe, if byte == 0 or byte > MAX_LEN, pulse `err_len` and go to IDLE. Otherwise store len, set chk = byte, idx = 0, go to PAYLOAD.
- PAYLOAD: on strobe, write buffer[idx] = byte, chk ^= byte, idx++. After writing idx == len-1, go to CHK.
- CHK: on strobe, if byte == chk, go to HOLD with `frame_valid` = 1 and `frame_len` = len. Otherwise pulse `err_chk` and go to IDLE.
- HOLD: `frame_ack` clears `frame_valid` and returns to IDLE.
  - A strobe in HOLD is dropped and pulses `err_ovf`. Buffer and `frame_len` are unchanged.
  - A strobe in the same cycle as `frame_ack`: ack takes effect, the byte is dropped, `err_ovf` pulses.
- `frame_ack` outside HOLD is ignored.
- Timeout: 16-bit gap counter, active in LEN/PAYLOAD/CHK.
  - Cleared on every strobe; increments each non-strobe cycle.
  - When it reaches TIMEOUT-1 on a non-strobe cycle: pulse `err_timeout`, go to IDLE.
  - If a strobe and the timeout fall in the same cycle, the strobe wins: the byte is processed and the counter cleared.
  - Counter held at 0 in IDLE and HOLD.
- Buffer: MAX_LEN x 8 register array, not reset.
  - `rd_byte` is meaningful only while `frame_valid` = 1 and `rd_addr` < `frame_len`; otherwise it returns stale data.
  - A rejected frame may overwrite buffer contents. This is safe because `frame_valid` is 0 during reception.

## Timing
- Reset (async assert, sync-safe deassert) sets state IDLE, `frame_valid` 0, `frame_len` 0, all `err_*` 0, idx 0, chk 0, gap counter 0, `fin_q` 1.
- Reset asserted mid-frame aborts the frame with no error pulse.
- One byte is processed per strobe. A strobe is processed at the first rising edge where `rx_finish` is 1 and `fin_q` is 0.
- `frame_valid` is high starting the cycle after the CHK byte's strobe edge.
- Each `err_*` is high for exactly one cycle, the cycle after the offending strobe or timeout edge. At most one `err_*` is asserted per cycle.
- `frame_valid` falls the cycle after the `frame_ack` edge. The next `SOF` can be accepted from that cycle on.
- Timeout abort fires exactly TIMEOUT clock edges after the last strobe edge.
- `rd_byte` has zero-cycle latency from `rd_addr`.

## Test plan
- Good frame A5 03 11 22 33 03 → `frame_valid`=1, `frame_len`=3, `rd_byte` at addr 0/1/2 = 11/22/33. `frame_ack` → `frame_valid`=0 next cycle.
- Bad checksum A5 02 10 20 FF (expected 32) → single `err_chk` pulse, `frame_valid` stays 0. Following good frame is accepted.
- Length fields 00 and 11 (17 > MAX_LEN=16) → `err_len` each time. Length 10 with 16 bytes and correct CHK → `frame_len`=16.
- A5 02 10 then idle → `err_timeout` exactly TIMEOUT edges after the 10 strobe. Also: a strobe landing on the timeout cycle is processed and no error fires.
- Frame held, then bytes 55 66 arrive → two `err_ovf` pulses, buffer unchanged. Ack coincident with a strobe → ack applied, `err_ovf` pulses.
- Garbage 00 FF 7E before A5, `rx_finish` high at reset release, and reset asserted mid-payload → no strobe from reset release, no error pulses, and the next clean frame is received correctly.
